// File: rtl/instr_mem_loader_if.sv
// Loader-side bundle: load request, incoming byte stream, memory write port and CPU status.
// The master modport drives the request/byte stream; the slave modport is the loader itself.
interface instr_mem_loader_if #(
  parameter int INSTR_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     Start;
  logic [15:0]              WordCount;
  logic [7:0]               InByte;
  logic                     InValid;
  logic                     InReady;
  logic                     MemWrEn;
  logic [ADDRESS_WIDTH-1:0] MemWrAddress;
  logic [INSTR_WIDTH-1:0]   MemWrData;
  logic                     CpuHold;
  logic                     Done;
  logic                     Error;

  modport master (
    output Start, WordCount, InByte, InValid,
    input  InReady, MemWrEn, MemWrAddress, MemWrData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, WordCount, InByte, InValid,
    output InReady, MemWrEn, MemWrAddress, MemWrData, CpuHold, Done, Error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles a big-endian byte stream into instruction words and writes them to memory,
// one write cycle after each word's last byte; InReady is high only while collecting bytes.
module instr_mem_loader #(
  parameter int INSTR_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH     = 100
) (
  input  logic              CLK,
  input  logic              RST,
  instr_mem_loader_if.slave bus
);
  localparam int BYTES_PER_WORD = INSTR_WIDTH / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  logic [2:0]               state;
  logic [15:0]              word_total;
  logic [15:0]              word_idx;
  logic [7:0]               byte_idx;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [INSTR_WIDTH-1:0]   shreg;
  logic [INSTR_WIDTH-1:0]   next_word;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [INSTR_WIDTH-1:0]   wr_data;
  logic                     start_ok;
  logic                     last_byte;

  assign start_ok  = (bus.WordCount != 16'd0) &&
                     ({16'd0, bus.WordCount} <= 32'(MEM_DEPTH));
  assign last_byte = (byte_idx == 8'(BYTES_PER_WORD - 1));
  // Earlier bytes shift toward the MSB, so the first byte lands in the top byte.
  assign next_word = {shreg[INSTR_WIDTH-9:0], bus.InByte};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      word_total <= 16'd0;
      word_idx   <= 16'd0;
      byte_idx   <= 8'd0;
      addr       <= '0;
      shreg      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.Start) begin
            if (start_ok) begin
              word_total <= bus.WordCount;
              word_idx   <= 16'd0;
              byte_idx   <= 8'd0;
              addr       <= '0;
              state      <= RECV;
            end else begin
              state <= ERR;
            end
          end
        end
        RECV: begin
          if (bus.InValid) begin
            shreg <= next_word;
            if (last_byte) begin
              byte_idx <= 8'd0;
              wr_data  <= next_word;
              wr_addr  <= addr;
              state    <= WRITE;
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
        end
        WRITE: begin
          if (word_idx + 16'd1 == word_total) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + 16'd1;
            addr     <= addr + ADDRESS_WIDTH'(BYTES_PER_WORD);
            state    <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.InReady      = (state == RECV);
  assign bus.MemWrEn      = (state == WRITE);
  assign bus.MemWrAddress = wr_addr;
  assign bus.MemWrData    = wr_data;
  assign bus.CpuHold      = (state != DONE);
  assign bus.Done         = (state == DONE);
  assign bus.Error        = (state == ERR);
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes go into a queue, a negedge monitor checks them.
module tb_instr_mem_loader;
  logic CLK = 1'b0;
  logic RST;

  instr_mem_loader_if bus ();

  instr_mem_loader dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0 && bus.MemWrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                 bus.MemWrAddress, bus.MemWrData);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.MemWrAddress), 64'(mon_e.addr));
        check("wr_data", 64'(bus.MemWrData), 64'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] wc);
    bus.Start     = 1'b1;
    bus.WordCount = wc;
    tick();
    bus.Start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   budget;
    logic rdy;
    budget      = 50;
    bus.InValid = 1'b1;
    bus.InByte  = b;
    do begin
      rdy = bus.InReady;
      tick();
      budget--;
    end while (!rdy && budget > 0);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout actual InReady=0 required InReady=1 within 50 cycles");
    end
    bus.InValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 20;
    while (bus.Done !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, 64'(bus.Done), 64'd1);
  endtask

  task automatic check_err_state(input string tag);
    check({tag, "_error"},   64'(bus.Error),   64'd1);
    check({tag, "_cpuhold"}, 64'(bus.CpuHold), 64'd1);
    check({tag, "_inready"}, 64'(bus.InReady), 64'd0);
    check({tag, "_done"},    64'(bus.Done),    64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inready"}, 64'(bus.InReady),      64'd0);
    check({tag, "_wren"},    64'(bus.MemWrEn),      64'd0);
    check({tag, "_addr"},    64'(bus.MemWrAddress), 64'd0);
    check({tag, "_data"},    64'(bus.MemWrData),    64'd0);
    check({tag, "_cpuhold"}, 64'(bus.CpuHold),      64'd1);
    check({tag, "_done"},    64'(bus.Done),         64'd0);
    check({tag, "_error"},   64'(bus.Error),        64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    RST           = 1'b1;
    bus.Start     = 1'b0;
    bus.WordCount = 16'd0;
    bus.InByte    = 8'd0;
    bus.InValid   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    tick();

    // Rejected counts: zero and one past the memory depth.
    do_start(16'd0);
    check_err_state("wc0");
    do_start(16'd101);
    check_err_state("wc101");

    // Two-word load from the error state.
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'hAC010000);
    do_start(16'd2);
    send_word(32'h20080005);
    send_word(32'hAC010000);
    wait_done("two_word_done");
    check("two_word_cpuhold", 64'(bus.CpuHold), 64'd0);
    check("two_word_error",   64'(bus.Error),   64'd0);

    // Single word with InValid gaps; write appears the cycle after the 4th byte.
    expect_write(32'h0, 32'h8C020004);
    do_start(16'd1);
    send_byte(8'h8C);
    repeat (2) tick();
    check("gap_inready", 64'(bus.InReady), 64'd1);
    send_byte(8'h02);
    tick();
    send_byte(8'h00);
    repeat (3) tick();
    send_byte(8'h04);
    check("gap_wren_latency", 64'(bus.MemWrEn), 64'd1);
    tick();
    check("gap_wren_one_cycle", 64'(bus.MemWrEn), 64'd0);
    check("gap_done", 64'(bus.Done), 64'd1);
    check("gap_data_hold", 64'(bus.MemWrData), 64'h8C020004);

    // Reset in the middle of the third word.
    expect_write(32'h0, 32'h01020304);
    expect_write(32'h4, 32'h05060708);
    do_start(16'd3);
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_byte(8'h09);
    send_byte(8'h0A);
    RST = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    bus.InValid = 1'b1;
    bus.InByte  = 8'h0B;
    repeat (3) tick();
    RST = 1'b0;
    repeat (4) tick();
    check("post_rst_inready", 64'(bus.InReady), 64'd0);
    check("post_rst_cpuhold", 64'(bus.CpuHold), 64'd1);
    bus.InValid = 1'b0;
    check("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start pulse while receiving must not disturb the latched load.
    expect_write(32'h0, 32'hDEADBEEF);
    expect_write(32'h4, 32'hCAFEF00D);
    do_start(16'd2);
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_start(16'd1);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_word(32'hCAFEF00D);
    wait_done("ignore_start_done");

    // Reload from DONE restarts at address 0.
    expect_write(32'h0, 32'h12345678);
    do_start(16'd1);
    check("reload_cpuhold", 64'(bus.CpuHold), 64'd1);
    check("reload_inready", 64'(bus.InReady), 64'd1);
    send_word(32'h12345678);
    wait_done("reload_done");

    // Full-depth load; last word lands at 4*99.
    do_start(16'd100);
    for (int i = 0; i < 100; i++) begin
      w = {8'(i), 8'h5A, 8'(255 - i), 8'(i * 7)};
      expect_write(32'(i * 4), w);
      send_word(w);
    end
    wait_done("full_done");
    check("full_last_addr", 64'(bus.MemWrAddress), 64'h18C);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, instruction byte-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 100, number of instruction-memory words.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Start  input  1  load request, sampled in IDLE, DONE, ERR only.
REQ-007 SHALL have port WordCount  input  16  number of words to load, sampled with Start.
REQ-008 SHALL have port InByte  input  8  program byte stream.
REQ-009 SHALL have port InValid  input  1  InByte valid.
REQ-010 SHALL have port InReady  output  1  loader accepts InByte this cycle.
REQ-011 SHALL have port MemWrEn  output  1  instruction-memory write strobe.
REQ-012 SHALL have port MemWrAddress  output  ADDRESS_WIDTH  byte address of written word.
REQ-013 SHALL have port MemWrData  output  INSTR_WIDTH  word written.
REQ-014 SHALL have port CpuHold  output  1  keeps processor stalled while high.
REQ-015 SHALL have port Done  output  1  load finished successfully.
REQ-016 SHALL have port Error  output  1  rejected load request.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERR.
REQ-018 SHALL, in IDLE/DONE/ERR on Start=1: WordCount==0 or WordCount>MEM_DEPTH -> ERR; else latch WordCount, clear word counter, byte index and address to 0 -> RECV.
REQ-019 SHALL ignore Start while in RECV or WRITE.
REQ-020 SHALL drive InReady=1 only in RECV; a byte is transferred when InValid&&InReady at a rising edge.
REQ-021 SHALL assemble words big-endian: 1st byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
REQ-022 SHALL, on transfer of the 4th byte, move to WRITE the next cycle; InValid gaps in RECV hold all state.
REQ-023 SHALL, in WRITE, assert MemWrEn=1 for exactly one cycle with MemWrAddress = 4*(word index), MemWrData = assembled word (latency: 4th byte edge -> MemWrEn next cycle).
REQ-024 SHALL, leaving WRITE: if words written == latched count -> DONE; else address += 4, byte index = 0 -> RECV.
REQ-025 SHALL keep MemWrEn=0 in all states other than WRITE; MemWrAddress/MemWrData hold last value otherwise.
REQ-026 SHALL drive CpuHold=1 in IDLE, RECV, WRITE, ERR and CpuHold=0 only in DONE.
REQ-027 SHALL drive Done=1 only in DONE and Error=1 only in ERR.
REQ-028 SHALL never produce MemWrAddress above 4*(MEM_DEPTH-1); no wrap-around possible given REQ-018.
REQ-029 SHALL, on Start in DONE with valid count, restart loading from address 0 (CpuHold rises next cycle).

Reset
REQ-030 SHALL, on RST=1 asynchronously, enter IDLE and force InReady=0, MemWrEn=0, MemWrAddress=0, MemWrData=0, CpuHold=1, Done=0, Error=0.
REQ-031 SHALL, on RST mid-load, discard any partial word and perform no further write.
REQ-032 SHALL require Start after reset release before accepting bytes.

Verification
REQ-033 Start, WordCount=2, bytes 20,08,00,05,AC,01,00,00 -> writes (0x0,0x20080005), (0x4,0xAC010000), then Done=1, CpuHold=0.
REQ-034 Start, WordCount=0 and separately WordCount=101 -> Error=1, CpuHold=1, InReady=0, no MemWrEn.
REQ-035 WordCount=1 with InValid idle cycles between bytes 8C,02,00,04 -> single write 0x8C020004 at 0x0, one cycle after 4th byte.
REQ-036 RST asserted after 2 bytes of word 3 -> immediate IDLE outputs per REQ-030, no write of partial word.
REQ-037 Start pulse during RECV -> ignored; load completes as originally latched; then Start in DONE, WordCount=1 -> reload at address 0x0.
REQ-038 WordCount=100 full load -> last write at 0x18C, Done=1.
